// File: rtl/issue_sched.sv
// issue_sched: single-issue scheduler with register scoreboard and ALU round-robin.
// Define ISSUE_SCHED_PERF_EN to add the stall_count performance counter port.
module issue_sched #(
  parameter int NUM_ALU      = 2,
  parameter int REG_BITS     = 6,
  parameter int START_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_type,
  input  logic [2:0]          unit,
  input  logic [REG_BITS-1:0] r1_in_rn,
  input  logic [REG_BITS-1:0] r2_in_rn,
  input  logic [REG_BITS-1:0] rd_in_rn,
  input  logic [REG_BITS-1:0] rd2_in_rn,
  input  logic [REG_BITS-1:0] reg1_finished,
  input  logic [REG_BITS-1:0] reg2_finished,
  input  logic [NUM_ALU-1:0]  alu_busy,
  input  logic                advint_busy,
  input  logic                memunit_busy,
  input  logic                branch_busy,
  output logic                willIssue,
  output logic                stall,
  output logic [NUM_ALU-1:0]  alu_en,
  output logic                advint_en,
  output logic                memunit_en,
  output logic                branch_en,
`ifdef ISSUE_SCHED_PERF_EN
  output logic [31:0]         stall_count,
`endif
  output logic [REG_BITS-1:0] rd_out_rn,
  output logic [REG_BITS-1:0] rd2_out_rn
);

  localparam int NREG = 1 << REG_BITS;
  localparam int GW = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  localparam logic [3:0] SC = 4'(START_CYCLES);
  localparam logic [GW-1:0] LG_RST = GW'(NUM_ALU - 1);

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_nxt;
  logic [3:0]      st_cnt;
  logic            started;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   alu_pick;
  logic            alu_found;
  logic            is_alu;
  logic            is_adv;
  logic            is_mem;
  logic            is_br;
  logic            hazard;
  logic            free;
  int              idx;

  function automatic logic haz(
    input logic [NREG-1:0]     b,
    input logic [REG_BITS-1:0] r,
    input logic [REG_BITS-1:0] f1,
    input logic [REG_BITS-1:0] f2
  );
    return (r != '0) && b[r] && (r != f1) && (r != f2);
  endfunction

  assign started = (st_cnt == SC);
  assign is_alu  = ~unit[2];
  assign is_br   = (unit == 3'd7);
  assign is_adv  = ~instr_type & (unit == 3'd4);
  assign is_mem  = instr_type & unit[2] & ~is_br;

  assign hazard =
      haz(sb, r1_in_rn, reg1_finished, reg2_finished)
    | haz(sb, r2_in_rn, reg1_finished, reg2_finished)
    | haz(sb, rd_in_rn, reg1_finished, reg2_finished)
    | (is_adv & haz(sb, rd2_in_rn, reg1_finished, reg2_finished));

  assign stall = ~started | hazard;

  assign free = (is_alu & alu_found)
              | (is_adv & ~advint_busy)
              | (is_mem & ~memunit_busy)
              | (is_br & ~branch_busy);

  assign willIssue = ~stall & free;

  // Round-robin ALU pick starting just after the last grant
  always_comb begin
    alu_pick  = '0;
    alu_found = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_ALU; i++) begin
      idx = int'(last_grant) + 1 + i;
      if (idx >= NUM_ALU) idx = idx - NUM_ALU;
      if (!alu_found && !alu_busy[GW'(idx)]) begin
        alu_found = 1'b1;
        alu_pick  = GW'(idx);
      end
    end
  end

  // Scoreboard next state: clear completions, then set issued dests
  always_comb begin
    sb_nxt = sb;
    sb_nxt[reg1_finished] = 1'b0;
    sb_nxt[reg2_finished] = 1'b0;
    if (willIssue) begin
      sb_nxt[rd_in_rn] = 1'b1;
      if (is_adv) sb_nxt[rd2_in_rn] = 1'b1;
    end
    sb_nxt[0] = 1'b0;
  end

  // Scoreboard, startup counter and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb         <= '0;
      st_cnt     <= '0;
      last_grant <= LG_RST;
    end else begin
      sb <= sb_nxt;
      if (!started) st_cnt <= st_cnt + 4'd1;
      if (willIssue && is_alu) last_grant <= alu_pick;
    end
  end

  // One-cycle issue pulses with their destinations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_en     <= '0;
      advint_en  <= 1'b0;
      memunit_en <= 1'b0;
      branch_en  <= 1'b0;
      rd_out_rn  <= '0;
      rd2_out_rn <= '0;
    end else begin
      alu_en     <= (willIssue & is_alu) ? (NUM_ALU'(1) << alu_pick) : '0;
      advint_en  <= willIssue & is_adv;
      memunit_en <= willIssue & is_mem;
      branch_en  <= willIssue & is_br;
      rd_out_rn  <= willIssue ? rd_in_rn : '0;
      rd2_out_rn <= (willIssue & is_adv) ? rd2_in_rn : '0;
    end
  end

`ifdef ISSUE_SCHED_PERF_EN
  // Saturating count of post-startup stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (started && stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
